// File: rtl/clk_pattern_gen_if.sv
// Config port for clk_pattern_gen: one valid/ready transfer carries a channel
// index plus the new high, low and phase counts for that channel.
interface clk_pattern_gen_if #(
   parameter int CH_W  = 1,
   parameter int CNT_W = 8
);
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [CNT_W-1:0] cfg_ton;
   logic [CNT_W-1:0] cfg_toff;
   logic [CNT_W-1:0] cfg_phase;

   modport master (output cfg_valid, cfg_ch, cfg_ton, cfg_toff, cfg_phase,
                   input  cfg_ready);
   modport slave  (input  cfg_valid, cfg_ch, cfg_ton, cfg_toff, cfg_phase,
                   output cfg_ready);
endinterface

// File: rtl/clk_pattern_gen.sv
// clk_pattern_gen: CHANNELS independent registered square waves with
// run-time programmable high/low times. New settings land in a per-channel
// shadow and are copied to the active set only at a period boundary or while
// idle, so a running waveform is never truncated.
// Optional feature macro: PHASE_OFFSET_EN adds a per-channel start delay
// (PHASE state) applied on every IDLE -> run transition.
module clk_pattern_gen #(
   parameter int CHANNELS = 2,
   parameter int CNT_W    = 8,
   parameter int TON_DEF  = 5,
   parameter int TOFF_DEF = 5,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   clk_pattern_gen_if.slave    cfg,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] period_done
);

   typedef enum logic [1:0] {S_IDLE, S_PHASE, S_HIGH, S_LOW} state_e;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CHANNELS-1:0] pending;

`ifndef PHASE_OFFSET_EN
   logic [CNT_W-1:0] unused_phase;
   assign unused_phase = cfg.cfg_phase;
`endif

   // Ready is per target channel: a second write stalls until the shadow is consumed.
   // Out-of-range channel numbers always see ready and are dropped.
   always_comb begin
      cfg.cfg_ready = 1'b1;
      for (int i = 0; i < CHANNELS; i++)
         if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = !pending[i];
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] ton_q, ton_d, toff_q, toff_d;
      logic [CNT_W-1:0] sh_ton_q, sh_ton_d, sh_toff_q, sh_toff_d;
      logic             pend_q, pend_d, clk_q, clk_d, done_q, done_d;
      logic             wr, pe;
      logic [CNT_W-1:0] eff_ton, eff_toff;
      state_e           st_s;
      logic [CNT_W-1:0] st_c;
`ifdef PHASE_OFFSET_EN
      logic [CNT_W-1:0] phase_q, phase_d, sh_phase_q, sh_phase_d, eff_phase;
`endif

      // Next-state: handshake capture, shadow copy, waveform FSM and output decode.
      always_comb begin
         wr       = cfg.cfg_valid && !pend_q && (cfg.cfg_ch == CH_W'(i));
         eff_ton  = pend_q ? sh_ton_q  : ton_q;
         eff_toff = pend_q ? sh_toff_q : toff_q;
         // Last cycle of a period: end of LOW, or end of HIGH when there is no LOW.
         pe = en && cnt_q == ONE &&
              ((state_q == S_LOW) || (state_q == S_HIGH && toff_q == '0));
         // Period start using the settings about to become active.
         if (eff_ton != '0) begin
            st_s = S_HIGH; st_c = eff_ton;
         end else if (eff_toff != '0) begin
            st_s = S_LOW;  st_c = eff_toff;
         end else begin
            st_s = S_IDLE; st_c = '0;
         end
         state_d   = state_q;
         cnt_d     = cnt_q;
         ton_d     = ton_q;
         toff_d    = toff_q;
         sh_ton_d  = sh_ton_q;
         sh_toff_d = sh_toff_q;
         pend_d    = pend_q;
`ifdef PHASE_OFFSET_EN
         eff_phase  = pend_q ? sh_phase_q : phase_q;
         phase_d    = phase_q;
         sh_phase_d = sh_phase_q;
`endif
         if (wr) begin
            sh_ton_d  = cfg.cfg_ton;
            sh_toff_d = cfg.cfg_toff;
            pend_d    = 1'b1;
`ifdef PHASE_OFFSET_EN
            sh_phase_d = cfg.cfg_phase;
`endif
         end
         if (pend_q && (state_q == S_IDLE || pe)) begin
            ton_d  = sh_ton_q;
            toff_d = sh_toff_q;
            pend_d = 1'b0;
`ifdef PHASE_OFFSET_EN
            phase_d = sh_phase_q;
`endif
         end
         if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else begin
            case (state_q)
               S_IDLE: begin
`ifdef PHASE_OFFSET_EN
                  if (eff_phase != '0) begin
                     state_d = S_PHASE; cnt_d = eff_phase;
                  end else begin
                     state_d = st_s; cnt_d = st_c;
                  end
`else
                  state_d = st_s; cnt_d = st_c;
`endif
               end
`ifdef PHASE_OFFSET_EN
               // Delay ends without a boundary copy; use the active set.
               S_PHASE: begin
                  if (cnt_q > ONE)          cnt_d = cnt_q - ONE;
                  else if (ton_q != '0)  begin state_d = S_HIGH; cnt_d = ton_q;  end
                  else if (toff_q != '0) begin state_d = S_LOW;  cnt_d = toff_q; end
                  else                   begin state_d = S_IDLE; cnt_d = '0;     end
               end
`endif
               S_HIGH: begin
                  if (cnt_q > ONE)        cnt_d = cnt_q - ONE;
                  else if (toff_q != '0) begin state_d = S_LOW; cnt_d = toff_q; end
                  else                 begin state_d = st_s;  cnt_d = st_c;   end
               end
               S_LOW: begin
                  if (cnt_q > ONE) cnt_d = cnt_q - ONE;
                  else          begin state_d = st_s; cnt_d = st_c; end
               end
               default: begin
                  state_d = S_IDLE; cnt_d = '0;
               end
            endcase
         end
         clk_d  = en && (state_q == S_HIGH);
         done_d = pe;
      end

      // Channel state registers; reset restores defaults and drops any pending write.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ton_q     <= CNT_W'(TON_DEF);
            toff_q    <= CNT_W'(TOFF_DEF);
            sh_ton_q  <= CNT_W'(TON_DEF);
            sh_toff_q <= CNT_W'(TOFF_DEF);
            pend_q    <= 1'b0;
            clk_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef PHASE_OFFSET_EN
            phase_q    <= '0;
            sh_phase_q <= '0;
`endif
         end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ton_q     <= ton_d;
            toff_q    <= toff_d;
            sh_ton_q  <= sh_ton_d;
            sh_toff_q <= sh_toff_d;
            pend_q    <= pend_d;
            clk_q     <= clk_d;
            done_q    <= done_d;
`ifdef PHASE_OFFSET_EN
            phase_q    <= phase_d;
            sh_phase_q <= sh_phase_d;
`endif
         end
      end

      assign pending[i]     = pend_q;
      assign clk_out[i]     = clk_q;
      assign period_done[i] = done_q;
   end

endmodule

// File: tb/tb_clk_pattern_gen.sv
// Directed bench for clk_pattern_gen (CHANNELS=2, defaults 5/5).
module tb_clk_pattern_gen;
   localparam int CH = 2, CW = 8, CHW = 1;

   logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
   logic [CH-1:0] clk_out, period_done;
   int            checks = 0, errors = 0;

   clk_pattern_gen_if #(.CH_W(CHW), .CNT_W(CW)) cfg ();

   clk_pattern_gen #(.CHANNELS(CH), .CNT_W(CW), .TON_DEF(5), .TOFF_DEF(5)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cfg(cfg),
      .clk_out(clk_out), .period_done(period_done));

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic [CH-1:0] clk;
      logic [CH-1:0] done;
   } vec_t;
   vec_t tbl[21];

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drive_cfg(input logic v, input logic ch, input int ton, input int toff, input int ph);
      cfg.cfg_valid = v; cfg.cfg_ch = ch;
      cfg.cfg_ton = CW'(ton); cfg.cfg_toff = CW'(toff); cfg.cfg_phase = CW'(ph);
   endtask

   task automatic do_reset();
      en = 1'b0; drive_cfg(1'b0, 1'b0, 0, 0, 0);
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Defaults 5/5 with en sampled high at edge 0: rise at 1, done at 10, 20, ...
   function automatic logic def_clk(input int n);
      return (n > 0) && (((n - 1) % 10) < 5);
   endfunction
   function automatic logic def_done(input int n);
      return (n > 0) && (((n - 1) % 10) == 9);
   endfunction

   // ch1 after 2/6 lands at edge 30 and 3/3 lands at edge 38
   function automatic logic t2_clk(input int n);
      if (n <= 30) return def_clk(n);
      return (n == 31 || n == 32 || (n >= 39 && n <= 41));
   endfunction
   function automatic logic t2_done(input int n);
      if (n <= 30) return def_done(n);
      return (n == 38 || n == 44);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int n = 0; n < 21; n++) begin
         tbl[n].en   = 1'b1;
         tbl[n].clk  = {2{def_clk(n)}};
         tbl[n].done = {2{def_done(n)}};
      end

      // Reset state
      drive_cfg(1'b0, 1'b0, 0, 0, 0);
      #2;
      check("rst_clk_out", 16'(clk_out), 16'h0);
      check("rst_done", 16'(period_done), 16'h0);
      check("rst_ready", 16'(cfg.cfg_ready), 16'h1);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();

      // Defaults, both channels in lockstep
      for (int n = 0; n < 21; n++) begin
         en = tbl[n].en;
         tick();
         check($sformatf("def_n%0d", n), 16'({clk_out, period_done}), 16'({tbl[n].clk, tbl[n].done}));
      end

      // Mid-HIGH reconfig of ch1 plus a stalled second write
      do_reset();
      en = 1'b1;
      for (int n = 0; n < 45; n++) begin
         tick();
         check($sformatf("cfg_n%0d", n), 16'({clk_out, period_done}),
               16'({t2_clk(n), def_clk(n), t2_done(n), def_done(n)}));
         if (n == 20) begin
            drive_cfg(1'b1, 1'b1, 2, 6, 0); #1;
            check("cfg_ready_first", 16'(cfg.cfg_ready), 16'h1);
         end else if (n >= 21 && n <= 30) begin
            drive_cfg(1'b1, 1'b1, 3, 3, 0); #1;
            check($sformatf("cfg_ready_n%0d", n), 16'(cfg.cfg_ready), 16'(n == 30));
         end else begin
            cfg.cfg_valid = 1'b0;
         end
      end

      // Degenerate: ch0 0/4 (LOW only), ch1 3/0 (HIGH only), loaded while idle
      do_reset();
      drive_cfg(1'b1, 1'b0, 0, 4, 0); #1;
      check("deg_ready0", 16'(cfg.cfg_ready), 16'h1);
      tick();
      drive_cfg(1'b1, 1'b1, 3, 0, 0); #1;
      check("deg_ready1", 16'(cfg.cfg_ready), 16'h1);
      tick();
      cfg.cfg_valid = 1'b0;
      repeat (2) tick();
      en = 1'b1;
      for (int n = 0; n < 13; n++) begin
         tick();
         check($sformatf("deg_n%0d", n), 16'({clk_out, period_done}),
               16'({(n >= 1), 1'b0, (n > 0 && n % 3 == 0), (n > 0 && n % 4 == 0)}));
      end

      // en dropped mid-HIGH for 7 edges, then restart
      do_reset();
      for (int n = 0; n < 23; n++) begin
         logic c, d;
         en = !(n >= 3 && n <= 9);
         tick();
         if (n < 3)        begin c = def_clk(n);      d = def_done(n);      end
         else if (n <= 10) begin c = 1'b0;            d = 1'b0;             end
         else              begin c = def_clk(n - 10); d = def_done(n - 10); end
         check($sformatf("en_n%0d", n), 16'({clk_out, period_done}), 16'({c, c, d, d}));
      end

`ifdef PHASE_OFFSET_EN
      // ch1 phase 3: rises three cycles after ch0
      do_reset();
      drive_cfg(1'b1, 1'b1, 5, 5, 3);
      tick();
      cfg.cfg_valid = 1'b0;
      repeat (2) tick();
      en = 1'b1;
      for (int n = 0; n < 7; n++) begin
         tick();
         check($sformatf("phase_n%0d", n), 16'(clk_out), 16'({(n >= 4), (n >= 1)}));
      end
`endif

      // Async reset mid-LOW with a pending write on ch1
      do_reset();
      en = 1'b1;
      for (int n = 0; n < 10; n++) begin
         tick();
         check($sformatf("ar_pre_n%0d", n), 16'(clk_out), 16'({2{def_clk(n)}}));
         if (n == 5) drive_cfg(1'b1, 1'b1, 2, 6, 0);
         else        cfg.cfg_valid = 1'b0;
      end
      #1;
      check("ar_pending", 16'(cfg.cfg_ready), 16'h0);
      #1 rst_n = 1'b0;
      #1;
      check("ar_outputs", 16'({clk_out, period_done}), 16'h0);
      check("ar_ready", 16'(cfg.cfg_ready), 16'h1);
      #1 rst_n = 1'b1;
      for (int n = 0; n < 12; n++) begin
         tick();
         check($sformatf("ar_post_n%0d", n), 16'({clk_out, period_done}),
               16'({{2{def_clk(n)}}, {2{def_done(n)}}}));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
